wb_fir_stream_bridge: RTL

Converts Wishbone accesses in the FIR stream window into AXI-Stream traffic for the FIR core.
- Sits between the user-project Wishbone decoder and the FIR ss_*/sm_* ports.
- Buffers X samples written by firmware and drives them into FIR.
- Buffers Y results from FIR until firmware reads them.
- Generates tlast from a programmable sample length.

---
 rtl/wb_fir_pkg.sv | 44 ++++
 rtl/wb_fir_stream_bridge_if.sv | 37 +++
 rtl/wb_fir_stream_bridge_sync_fifo.sv | 52 +++++
 rtl/wb_fir_stream_bridge.sv | 137 +++++++++++++
 4 files changed

// File: rtl/wb_fir_pkg.sv
// Shared definitions for the Wishbone <-> FIR stream bridge.
// Contents: register offsets inside the 0x80..0xFF window, STATUS bit
// positions, the access-type enum and small decode/pack helpers.
package wb_fir_pkg;

    localparam logic [7:0] OFS_X    = 8'h80;
    localparam logic [7:0] OFS_Y    = 8'h84;
    localparam logic [7:0] OFS_LEN  = 8'h88;
    localparam logic [7:0] OFS_STAT = 8'h8C;

    localparam int unsigned STAT_X_LVL_LSB  = 0;
    localparam int unsigned STAT_Y_LVL_LSB  = 4;
    localparam int unsigned STAT_Y_LAST_BIT = 11;

    typedef enum logic [2:0] {
        AccX,
        AccY,
        AccLen,
        AccStat,
        AccOther
    } acc_e;

    function automatic acc_e decode_ofs(input logic [7:0] ofs);
        case (ofs)
            OFS_X:    return AccX;
            OFS_Y:    return AccY;
            OFS_LEN:  return AccLen;
            OFS_STAT: return AccStat;
            default:  return AccOther;
        endcase
    endfunction

    function automatic logic [31:0] pack_status(input logic y_last,
                                                input logic [3:0] y_lvl,
                                                input logic [3:0] x_lvl);
        logic [31:0] s;
        s = '0;
        s[STAT_X_LVL_LSB +: 4] = x_lvl;
        s[STAT_Y_LVL_LSB +: 4] = y_lvl;
        s[STAT_Y_LAST_BIT]     = y_last;
        return s;
    endfunction

endpackage

// File: rtl/wb_fir_stream_bridge_if.sv
// Bus bundle of the bridge: Wishbone slave signals (with decoder select),
// the X stream towards the FIR (ss_*) and the Y stream from the FIR (sm_*).
// Modport slave is the bridge view, master is the firmware/FIR view.
interface wb_fir_stream_bridge_if #(
    parameter int unsigned DATA_W = 32
);
    logic              sel_i;
    logic              wbs_cyc_i;
    logic              wbs_stb_i;
    logic              wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [7:0]        wbs_adr_i;
    logic [31:0]       wbs_dat_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;
    logic              ss_tvalid;
    logic [DATA_W-1:0] ss_tdata;
    logic              ss_tlast;
    logic              ss_tready;
    logic              sm_tvalid;
    logic [DATA_W-1:0] sm_tdata;
    logic              sm_tlast;
    logic              sm_tready;

    modport slave (
        input  sel_i, wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  ss_tready, sm_tvalid, sm_tdata, sm_tlast,
        output wbs_ack_o, wbs_dat_o, ss_tvalid, ss_tdata, ss_tlast, sm_tready
    );

    modport master (
        output sel_i, wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output ss_tready, sm_tvalid, sm_tdata, sm_tlast,
        input  wbs_ack_o, wbs_dat_o, ss_tvalid, ss_tdata, ss_tlast, sm_tready
    );

endinterface

// File: rtl/wb_fir_stream_bridge_sync_fifo.sv
// Synchronous FIFO with registered occupancy count.
// Ports: clk/rst (sync, active-high), push/wdata, pop/rdata (head, valid
// while !empty), full, empty, count (0..DEPTH).
// Push when full and pop when empty are ignored; push+pop together keeps
// the count and advances both pointers. DEPTH must be a power of 2.
module sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    // Storage is not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= wdata;
    end

endmodule

// File: rtl/wb_fir_stream_bridge.sv
// Wishbone window -> AXI-Stream bridge for the FIR core.
// Ports: wb_clk_i, wb_rst_i (sync, active-high), bus (slave modport):
//   Wishbone slave with decoder select sel_i, X stream out (ss_*),
//   Y stream in (sm_*).
// Registers: 0x80 X push, 0x84 Y pop, 0x88 LEN (byte lanes), 0x8C STATUS.
// X pushes carry a tlast generated from LEN; Y pops update a sticky y_last.
module wb_fir_stream_bridge
    import wb_fir_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DATA_W  = 32,
    parameter logic [31:0] LEN_RST = 32'd64
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    wb_fir_stream_bridge_if.slave bus
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [DATA_W:0] x_wdata, x_rdata, y_wdata, y_rdata;
    logic            x_push, x_pop, x_full, x_empty;
    logic            y_push, y_pop, y_full, y_empty;
    logic [CntW-1:0] x_count, y_count;

    logic            ack_q, ack_d;
    logic [31:0]     dat_q, rd_d;
    logic [31:0]     len_q, in_cnt_q;
    logic            y_last_q;
    logic            req, len_wr, x_tlast;
    acc_e            acc;

    // ack_q masks the request so ack can never be high two cycles running.
    assign req = bus.wbs_cyc_i && bus.wbs_stb_i && bus.sel_i && !ack_q;
    assign acc = decode_ofs(bus.wbs_adr_i);

    assign x_tlast = (len_q != '0) && (in_cnt_q == len_q - 32'd1);
    assign x_wdata = {x_tlast, DATA_W'(bus.wbs_dat_i)};
    assign y_wdata = {bus.sm_tlast, bus.sm_tdata};

    assign x_pop  = !x_empty && bus.ss_tready;
    assign y_push = bus.sm_tvalid && bus.sm_tready;

    assign bus.ss_tvalid = !x_empty;
    assign bus.ss_tdata  = x_rdata[DATA_W-1:0];
    assign bus.ss_tlast  = x_rdata[DATA_W];
    // Held low during reset so the FIR cannot hand over data being flushed.
    assign bus.sm_tready = !y_full && !wb_rst_i;
    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_dat_o = dat_q;

    always_comb begin
        ack_d  = 1'b0;
        rd_d   = '0;
        x_push = 1'b0;
        y_pop  = 1'b0;
        len_wr = 1'b0;
        if (req) begin
            unique case (acc)
                AccX: begin
                    // Full check uses the registered count: a same-cycle
                    // stream pop does not make room for this push.
                    x_push = bus.wbs_we_i && !x_full;
                    ack_d  = !bus.wbs_we_i || !x_full;
                end
                AccY: begin
                    y_pop = !bus.wbs_we_i && !y_empty;
                    ack_d = bus.wbs_we_i || !y_empty;
                    if (!bus.wbs_we_i) rd_d = 32'(y_rdata[DATA_W-1:0]);
                end
                AccLen: begin
                    len_wr = bus.wbs_we_i;
                    ack_d  = 1'b1;
                    if (!bus.wbs_we_i) rd_d = len_q;
                end
                AccStat: begin
                    ack_d = 1'b1;
                    if (!bus.wbs_we_i) rd_d = pack_status(y_last_q, 4'(y_count), 4'(x_count));
                end
                default: ack_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            len_q    <= LEN_RST;
            in_cnt_q <= '0;
            y_last_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            dat_q <= ack_d ? rd_d : '0;
            if (len_wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.wbs_sel_i[i]) len_q[8*i +: 8] <= bus.wbs_dat_i[8*i +: 8];
                end
                in_cnt_q <= '0;
                y_last_q <= 1'b0;
            end else begin
                if (x_push) in_cnt_q <= x_tlast ? '0 : in_cnt_q + 32'd1;
                if (y_pop && y_rdata[DATA_W]) y_last_q <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH(DATA_W + 1),
        .DEPTH(DEPTH)
    ) u_x_fifo (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .push (x_push),
        .wdata(x_wdata),
        .pop  (x_pop),
        .rdata(x_rdata),
        .full (x_full),
        .empty(x_empty),
        .count(x_count)
    );

    sync_fifo #(
        .WIDTH(DATA_W + 1),
        .DEPTH(DEPTH)
    ) u_y_fifo (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .push (y_push),
        .wdata(y_wdata),
        .pop  (y_pop),
        .rdata(y_rdata),
        .full (y_full),
        .empty(y_empty),
        .count(y_count)
    );

endmodule
